// File: rtl/prio_select.sv
// prio_select: pipelined 64-way priority argmax over the square cells.
// Returns the winning square (highest priority, lowest index on ties), its
// priority, an any-king flag, and a registered one-hot select toward the squares.
// Build option: define PRIO_SELECT_EXCLUDE_EN to add the retire/clear_excl
// exclusion mask, used to walk candidates in descending priority order.
module prio_select #(
  parameter int PRIO_W = 3,
  parameter int NSQ    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NSQ*PRIO_W-1:0] prio_in,
  input  logic [NSQ-1:0]        king_in,
`ifdef PRIO_SELECT_EXCLUDE_EN
  input  logic                  retire,
  input  logic                  clear_excl,
`endif
  output logic                  done,
  output logic                  found,
  output logic [PRIO_W-1:0]     best_prio,
  output logic [5:0]            best_sq,
  output logic                  king_hit,
  output logic [NSQ-1:0]        ss1_out
);

  localparam int IDX_W = 6;
  localparam int N1    = NSQ / 4;  // candidates after stage 1
  localparam int N2    = N1 / 4;   // candidates after stage 2

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [IDX_W-1:0]  idx;
  } cand_t;

  // Operands are always passed lower-index first, so ">=" keeps the lower
  // index on a tie and the global result is the lowest index of the max.
  function automatic cand_t pick2(input cand_t lo, input cand_t hi);
    return (lo.prio >= hi.prio) ? lo : hi;
  endfunction

  function automatic cand_t pick4(input cand_t c0, input cand_t c1,
                                  input cand_t c2, input cand_t c3);
    return pick2(pick2(c0, c1), pick2(c2, c3));
  endfunction

  function automatic cand_t leaf(input logic [NSQ*PRIO_W-1:0] p, input int n);
    cand_t c;
    c.prio = p[n*PRIO_W +: PRIO_W];
    c.idx  = IDX_W'(n);
    return c;
  endfunction

  logic [NSQ*PRIO_W-1:0] masked_prio;
  logic [NSQ*PRIO_W-1:0] in_prio;
  logic [NSQ-1:0]        in_king;
  cand_t                 s1_d [N1];
  cand_t                 s1_c [N1];
  logic [N1-1:0]         s1_kd, s1_k;
  cand_t                 s2_d [N2];
  cand_t                 s2_c [N2];
  logic [N2-1:0]         s2_kd, s2_k;
  cand_t                 fin;
  logic                  fin_king;
  logic                  v0, v1, v2;

`ifdef PRIO_SELECT_EXCLUDE_EN
  logic [NSQ-1:0] excl;

  // Exclusion mask: clear beats retire; retire marks the currently held winner.
  always_ff @(posedge clk) begin
    if (rst)                excl <= '0;
    else if (clear_excl)    excl <= '0;
    else if (retire && found) excl[best_sq] <= 1'b1;
  end
`endif

  // Priorities as seen at start: excluded squares are forced to zero.
  always_comb begin
    // NOTE: every signal written here gets a full default first, so no
    // path leaves it unassigned and no latch is inferred.
    masked_prio = prio_in;
`ifdef PRIO_SELECT_EXCLUDE_EN
    for (int n = 0; n < NSQ; n++)
      if (excl[n]) masked_prio[n*PRIO_W +: PRIO_W] = '0;
`endif
  end

  // Stage 1 and 2 reductions: 64 -> 16 -> 4, king flags OR-ed alongside.
  always_comb begin
    for (int g = 0; g < N1; g++) begin
      s1_d[g]  = pick4(leaf(in_prio, 4*g), leaf(in_prio, 4*g+1),
                       leaf(in_prio, 4*g+2), leaf(in_prio, 4*g+3));
      s1_kd[g] = |in_king[4*g +: 4];
    end
    for (int g = 0; g < N2; g++) begin
      s2_d[g]  = pick4(s1_c[4*g], s1_c[4*g+1], s1_c[4*g+2], s1_c[4*g+3]);
      s2_kd[g] = |s1_k[4*g +: 4];
    end
    fin      = pick4(s2_c[0], s2_c[1], s2_c[2], s2_c[3]);
    fin_king = |s2_k;
  end

  // Datapath registers; qualified by the valid chain, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: only control state (valids, outputs) is reset; wide datapath
    // registers are don't-care until a valid bit marks them as meaningful.
    if (start) begin
      in_prio <= masked_prio;
      in_king <= king_in;
    end
    s1_c <= s1_d;
    s1_k <= s1_kd;
    s2_c <= s2_d;
    s2_k <= s2_kd;
  end

  // Valid chain; reset flushes in-flight operations and wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0   <= 1'b0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      done <= 1'b0;
    end else begin
      v0   <= start;
      v1   <= v0;
      v2   <= v1;
      done <= v2;
    end
  end

  // Result registers: load with the stage-3 result, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      found     <= 1'b0;
      best_prio <= '0;
      best_sq   <= '0;
      king_hit  <= 1'b0;
      ss1_out   <= '0;
    end else if (v2) begin
      found     <= (fin.prio != '0);
      best_prio <= fin.prio;
      best_sq   <= (fin.prio != '0) ? fin.idx : '0;
      king_hit  <= fin_king;
      ss1_out   <= (fin.prio != '0) ? ({{(NSQ-1){1'b0}}, 1'b1} << fin.idx) : '0;
    end
  end

endmodule

// File: doc/prio_select.md
Name: prio_select

Overview:
- Downstream consumer of the 64 square cells' `prio[2:0]` and `king` outputs.
- Performs a pipelined 64-way argmax and returns the winning square index, its priority and an any-king flag.
- Drives a registered one-hot square-select vector back toward the squares' `ss1` inputs.
- The move-sequencing controller pulses `start` once per evaluated state_mode phase.

Parameters:
- PRIO_W, 3, width of each square's priority field; only 3 is supported.
- NSQ, 64, number of squares; only 64 is supported (index width 6).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  sample `prio_in`/`king_in` this cycle
- prio_in  input  192  square n priority at bits [3n+2:3n]; square 0 = a1, square 63 = h8
- king_in  input  64  square n king-victim flag at bit n
- done  output  1  one-cycle pulse, result registers updated this cycle
- found  output  1  best_prio != 0
- best_prio  output  3  winning priority
- best_sq  output  6  winning square index
- king_hit  output  1  OR of sampled `king_in`
- ss1_out  output  64  one-hot of `best_sq` when `found`, else all zero

Behaviour:
- Reset (rst=1 at clk edge):
  - `done`, `found`, `best_prio`, `best_sq`, `king_hit`, `ss1_out` all become 0.
  - All pipeline valid bits clear.
  - In-flight operations are discarded and never produce `done`.
- Pipeline, three registered 4:1 reduction stages:
  - S1: 64 to 16 candidates. S2: 16 to 4. S3: 4 to 1, and the output registers load.
  - Each candidate is {prio[2:0], idx[5:0]}. `king_in` is OR-reduced alongside in the same stages.
- Latency: `start` sampled at edge k gives `done`=1 and updated outputs after edge k+3.
- Fully pipelined:
  - `start` may be asserted on consecutive cycles; each assertion yields exactly one `done`, in order.
  - Inputs need only be valid in the `start` cycle.
- Compare rule:
  - Higher prio wins.
  - On equal prio, the lower square index wins. This applies at every stage, so the global result is the lowest index among the maximum priority.
- All-zero priorities: `found`=0, `best_prio`=0, `best_sq`=0, `ss1_out`=0, `done` still pulses.
- Output registers (`found`, `best_prio`, `best_sq`, `king_hit`, `ss1_out`) hold their value between `done` pulses and change only on the `done` cycle or on reset.
- `ss1_out`:
  - Decoded from the stage-3 result and registered together with `best_sq`, so both are always mutually consistent.
  - Never more than one bit set.
- `rst` and `start` in the same cycle: reset wins and the start is dropped.

Optional Feature:
- Macro: PRIO_SELECT_EXCLUDE_EN.
- With the macro, the following are added:
  - Input ports `retire` (1) and `clear_excl` (1).
  - A 64-bit `excl` register, reset to 0.
- Exclusion: at `start`, square n's priority is forced to 0 when `excl[n]`=1.
- `retire`=1 sets `excl[best_sq]`, using the currently held output, only when `found`=1; it has no effect otherwise.
- `clear_excl`=1 zeroes `excl`.
- `clear_excl` and `retire` in the same cycle: clear wins.
- `retire` and `start` in the same cycle: the start samples `excl` before the retire takes effect.
- This lets the controller iterate victims/aggressors in descending priority without re-masking the squares.
- Without the macro: the ports and register do not exist and priorities pass unmodified.

Test Plan:
- All prio 0, one `start` -> `done` exactly 3 cycles later; `found`=0, `best_sq`=0, `ss1_out`=0.
- prio[10]=5, prio[40]=7, prio[63]=7, others 0 -> `best_prio`=7, `best_sq`=40, `ss1_out`=1<<40, `found`=1.
- Tie: prio[0]=prio[17]=prio[33]=3, others 0 -> `best_sq`=0; then only prio[17]=prio[33]=3 -> `best_sq`=17.
- Back-to-back `start` on 3 cycles with winners 12, 50, 7 -> three consecutive `done` pulses with `best_sq` 12, 50, 7 in order; `king_in[50]`=1 in the second input only -> `king_hit` 0,1,0.
- `start`, then `rst` one cycle later -> no `done` ever appears; all outputs 0.
- (PRIO_SELECT_EXCLUDE_EN)
  - prio[5]=6, prio[9]=4 -> `best_sq`=5; `retire`, re-`start` -> `best_sq`=9.
  - `retire`, re-`start` -> `found`=0.
  - `clear_excl`, re-`start` -> `best_sq`=5.
